// File: rtl/wfg_drive_spi_arb.sv
// Two-source AXI-Stream arbiter feeding the SPI drive stream; frame-locked grants, fixed or round-robin.
// Optional per-source completed-frame counters are built when WFG_DRIVE_SPI_ARB_STATS_EN is defined.
module wfg_drive_spi_arb #(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       ctrl_en_i,
    input  logic                       cfg_rr_i,
    input  logic                       s0_axis_tvalid_i,
    input  logic                       s0_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s0_axis_tdata_i,
    output logic                       s0_axis_tready_o,
    input  logic                       s1_axis_tvalid_i,
    input  logic                       s1_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s1_axis_tdata_i,
    output logic                       s1_axis_tready_o,
    output logic                       m_axis_tvalid_o,
    output logic                       m_axis_tlast_o,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
    input  logic                       m_axis_tready_i,
    output logic [1:0]                 grant_o,
    output logic [15:0]                frame_cnt0_o,
    output logic [15:0]                frame_cnt1_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state;
    logic       last_ptr;
    logic [1:0] grant_q;
    logic       pick1;
    logic       eof0;
    logic       eof1;

    assign eof0 = (state == GNT0) && s0_axis_tvalid_i && m_axis_tready_i && s0_axis_tlast_i;
    assign eof1 = (state == GNT1) && s1_axis_tvalid_i && m_axis_tready_i && s1_axis_tlast_i;

    // Winner of the IDLE decision; only consulted when at least one source is valid.
    always_comb begin
        if (cfg_rr_i && s0_axis_tvalid_i && s1_axis_tvalid_i)
            pick1 = ~last_ptr;
        else
            pick1 = ~s0_axis_tvalid_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_ptr <= 1'b1;
            grant_q  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_en_i && (s0_axis_tvalid_i || s1_axis_tvalid_i)) begin
                        last_ptr <= pick1;
                        if (pick1) begin
                            state   <= GNT1;
                            grant_q <= 2'b10;
                        end else begin
                            state   <= GNT0;
                            grant_q <= 2'b01;
                        end
                    end
                end
                GNT0: begin
                    if (eof0) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                GNT1: begin
                    if (eof1) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant_o = grant_q;

    // NOTE: every output gets a default first so the mux cannot infer a latch.
    always_comb begin
        m_axis_tvalid_o  = 1'b0;
        m_axis_tlast_o   = 1'b0;
        m_axis_tdata_o   = '0;
        s0_axis_tready_o = 1'b0;
        s1_axis_tready_o = 1'b0;
        case (state)
            GNT0: begin
                m_axis_tvalid_o  = s0_axis_tvalid_i;
                m_axis_tlast_o   = s0_axis_tlast_i;
                m_axis_tdata_o   = s0_axis_tdata_i;
                s0_axis_tready_o = m_axis_tready_i;
            end
            GNT1: begin
                m_axis_tvalid_o  = s1_axis_tvalid_i;
                m_axis_tlast_o   = s1_axis_tlast_i;
                m_axis_tdata_o   = s1_axis_tdata_i;
                s1_axis_tready_o = m_axis_tready_i;
            end
            default: ;
        endcase
    end

`ifdef WFG_DRIVE_SPI_ARB_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    // Counters saturate rather than wrap so a long run never reads as few frames.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else begin
            if (eof0 && (cnt0 != 16'hFFFF))
                cnt0 <= cnt0 + 16'h0001;
            if (eof1 && (cnt1 != 16'hFFFF))
                cnt1 <= cnt1 + 16'h0001;
        end
    end

    assign frame_cnt0_o = cnt0;
    assign frame_cnt1_o = cnt1;
`else
    assign frame_cnt0_o = 16'h0000;
    assign frame_cnt1_o = 16'h0000;
`endif

endmodule

// File: tb/tb_wfg_drive_spi_arb.sv
// Directed bench for wfg_drive_spi_arb: single frame, round-robin, fixed priority, backpressure,
// enable drop, mid-frame reset and frame counters (expected per WFG_DRIVE_SPI_ARB_STATS_EN).
module tb_wfg_drive_spi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rr;
    logic        s0_tvalid, s0_tlast, s0_tready;
    logic [31:0] s0_tdata;
    logic        s1_tvalid, s1_tlast, s1_tready;
    logic [31:0] s1_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] m_tdata;
    logic [1:0]  grant;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    // Bench-side source model: each source walks base+idx beats and issues `left` frames.
    logic        src_valid [2];
    int          src_idx   [2];
    int          src_len   [2];
    int          src_left  [2];
    logic [31:0] src_base  [2];

    always #5 clk = ~clk;

    wfg_drive_spi_arb #(.AXIS_DATA_WIDTH(32)) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .ctrl_en_i        (en),
        .cfg_rr_i         (rr),
        .s0_axis_tvalid_i (s0_tvalid),
        .s0_axis_tlast_i  (s0_tlast),
        .s0_axis_tdata_i  (s0_tdata),
        .s0_axis_tready_o (s0_tready),
        .s1_axis_tvalid_i (s1_tvalid),
        .s1_axis_tlast_i  (s1_tlast),
        .s1_axis_tdata_i  (s1_tdata),
        .s1_axis_tready_o (s1_tready),
        .m_axis_tvalid_o  (m_tvalid),
        .m_axis_tlast_o   (m_tlast),
        .m_axis_tdata_o   (m_tdata),
        .m_axis_tready_i  (m_tready),
        .grant_o          (grant),
        .frame_cnt0_o     (cnt0),
        .frame_cnt1_o     (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        s0_tvalid = src_valid[0];
        s0_tdata  = src_valid[0] ? src_base[0] + 32'(src_idx[0]) : 32'h0;
        s0_tlast  = src_valid[0] && (src_idx[0] == src_len[0] - 1);
        s1_tvalid = src_valid[1];
        s1_tdata  = src_valid[1] ? src_base[1] + 32'(src_idx[1]) : 32'h0;
        s1_tlast  = src_valid[1] && (src_idx[1] == src_len[1] - 1);
    endtask

    task automatic advance(input int n);
        if (src_idx[n] == src_len[n] - 1) begin
            src_idx[n]  = 0;
            src_left[n] = src_left[n] - 1;
            src_base[n] = src_base[n] + 32'h10;
            if (src_left[n] == 0)
                src_valid[n] = 1'b0;
        end else begin
            src_idx[n] = src_idx[n] + 1;
        end
    endtask

    task automatic start_src(input int n, input logic [31:0] base, input int len, input int frames);
        src_valid[n] = 1'b1;
        src_idx[n]   = 0;
        src_len[n]   = len;
        src_left[n]  = frames;
        src_base[n]  = base;
        drive();
        #1;
    endtask

    // Handshakes are taken before the edge; sources advance just after it; returns on the negedge.
    task automatic tick();
        logic hs0, hs1;
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        @(posedge clk);
        #1;
        if (hs0) advance(0);
        if (hs1) advance(1);
        drive();
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int n = 0; n < 2; n++) begin
            src_valid[n] = 1'b0;
            src_idx[n]   = 0;
            src_len[n]   = 1;
            src_left[n]  = 0;
            src_base[n]  = 32'h0;
        end
        drive();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [1:0]  rr_grants [13] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                    2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [31:0] bp_data [8] = '{32'h0, 32'hB0, 32'hB1, 32'hB1, 32'hB2, 32'hB2, 32'hB3, 32'hB3};

    initial begin
        rst = 1'b1; en = 1'b1; rr = 1'b0; m_tready = 1'b1;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_mvalid", 32'(m_tvalid), 32'h0);
        check("rst_cnt0", 32'(cnt0), 32'h0);
        check("rst_cnt1", 32'(cnt1), 32'h0);

        // Single 3-beat s0 frame
        start_src(0, 32'hA1, 3, 1);
        check("f1_c0_grant", 32'(grant), 32'h0);
        check("f1_c0_tready0", 32'(s0_tready), 32'h0);
        check("f1_c0_mvalid", 32'(m_tvalid), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("f1_c%0d_grant", c), 32'(grant), 32'h1);
            check($sformatf("f1_c%0d_mvalid", c), 32'(m_tvalid), 32'h1);
            check($sformatf("f1_c%0d_data", c), m_tdata, 32'hA0 + 32'(c));
            check($sformatf("f1_c%0d_last", c), 32'(m_tlast), (c == 3) ? 32'h1 : 32'h0);
            check($sformatf("f1_c%0d_tready0", c), 32'(s0_tready), 32'h1);
        end
        tick();
        check("f1_c4_grant", 32'(grant), 32'h0);
        check("f1_c4_mvalid", 32'(m_tvalid), 32'h0);
        check("f1_c4_mdata", m_tdata, 32'h0);

        // Round-robin alternation
        do_reset();
        rr = 1'b1;
        start_src(0, 32'hA0, 2, 2);
        start_src(1, 32'hB0, 2, 2);
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            check($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(rr_grants[c]));
        end

        // Fixed priority with both continuously valid
        do_reset();
        rr = 1'b0;
        start_src(0, 32'hA0, 2, 3);
        start_src(1, 32'hB0, 2, 3);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            check($sformatf("fp_c%0d_grant", c), 32'(grant), (c % 3 == 0) ? 32'h0 : 32'h1);
            check($sformatf("fp_c%0d_tready1", c), 32'(s1_tready), 32'h0);
        end

        // Backpressure on an s1 4-beat frame
        do_reset();
        m_tready = 1'b0;
        start_src(1, 32'hB0, 4, 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            m_tready = (c % 2 == 1);
            #1;
            check($sformatf("bp_c%0d_grant", c), 32'(grant), (c <= 7) ? 32'h2 : 32'h0);
            check($sformatf("bp_c%0d_tready0", c), 32'(s0_tready), 32'h0);
            if (c <= 7) begin
                check($sformatf("bp_c%0d_data", c), m_tdata, bp_data[c]);
                check($sformatf("bp_c%0d_tready1", c), 32'(s1_tready), 32'(m_tready));
            end
        end
        m_tready = 1'b1;

        // Enable dropped mid-frame, then mid-frame reset
        do_reset();
        en = 1'b1;
        start_src(0, 32'hC0, 4, 1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) en = 1'b0;
            #1;
            check($sformatf("en_c%0d_grant", c), 32'(grant), 32'h1);
            check($sformatf("en_c%0d_data", c), m_tdata, 32'hBF + 32'(c));
        end
        tick();
        check("en_c5_grant", 32'(grant), 32'h0);
        start_src(0, 32'hD0, 2, 1);
        for (int c = 6; c <= 7; c++) begin
            tick();
            check($sformatf("en_c%0d_off_grant", c), 32'(grant), 32'h0);
        end
        en = 1'b1;
        #1;
        tick();
        check("en_on_grant", 32'(grant), 32'h1);
        check("en_on_data", m_tdata, 32'hD0);
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        check("mrst_grant", 32'(grant), 32'h0);
        check("mrst_mvalid", 32'(m_tvalid), 32'h0);
        check("mrst_mlast", 32'(m_tlast), 32'h0);
        check("mrst_mdata", m_tdata, 32'h0);
        check("mrst_tready0", 32'(s0_tready), 32'h0);

        // Frame counters
        do_reset();
        rr = 1'b1;
        start_src(0, 32'hA0, 2, 5);
        start_src(1, 32'hB0, 1, 3);
        begin
            int n;
            n = 0;
            while ((src_left[0] != 0 || src_left[1] != 0) && n < 200) begin
                tick();
                n++;
            end
            check("stats_done_in_time", 32'(n < 200), 32'h1);
        end
`ifdef WFG_DRIVE_SPI_ARB_STATS_EN
        check("stats_cnt0", 32'(cnt0), 32'd5);
        check("stats_cnt1", 32'(cnt1), 32'd3);
`else
        check("stats_cnt0", 32'(cnt0), 32'd0);
        check("stats_cnt1", 32'(cnt1), 32'd0);
`endif
        do_reset();
        check("stats_clr0", 32'(cnt0), 32'h0);
        check("stats_clr1", 32'(cnt1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
